// File: rtl/toy_dmem_responder.sv
// toy_dmem_responder: data-side responder for the RISC toy core.
// Serves a word-addressed RAM of 2^AW words plus a 4-word I/O window at
// IO_BASE: console (offset 0), cycle counter (1), halt flag (2), status (3).
// Read data is registered (one cycle of latency) and holds until the next read.
// Optional feature macro: DMEM_ERR_EN -- flags non-I/O accesses whose upper
// address bits are nonzero instead of letting them alias into the RAM.
module toy_dmem_responder #(
    parameter int          AW      = 10,
    parameter logic [29:0] IO_BASE = 30'h3FFFFFF0,
    parameter logic [31:0] CNT_RST = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DREQ,
    input  logic        DRW,
    input  logic [29:0] DADDR,
    input  logic [31:0] DWDATA,
    output logic [31:0] DRDATA,
    output logic        CONS_VALID,
    output logic [31:0] CONS_DATA,
    output logic        HALT,
    output logic        ERR
);

    localparam logic [1:0] OFF_CONS   = 2'd0;
    localparam logic [1:0] OFF_CNT    = 2'd1;
    localparam logic [1:0] OFF_HALT   = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    // Backing store; deliberately not cleared by reset.
    logic [31:0]   mem [2**AW];

    logic          io_hit_s;
    logic [1:0]    io_off_s;
    logic [AW-1:0] ram_idx_s;
    logic          bad_addr_s;
    logic          rd_req_s;
    logic          wr_req_s;
    logic          ram_we_s;
    logic          err_s;

    logic [31:0]   rdata_q,      rdata_d;
    logic          cons_valid_q, cons_valid_d;
    logic [31:0]   cons_data_q,  cons_data_d;
    logic          halt_q,       halt_d;
    logic [31:0]   cnt_q,        cnt_d;

    assign io_hit_s  = (DADDR[29:2] == IO_BASE[29:2]);
    assign io_off_s  = DADDR[1:0];
    assign ram_idx_s = DADDR[AW-1:0];
    assign rd_req_s  = DREQ & ~DRW;
    assign wr_req_s  = DREQ & DRW;
    // Out-of-range RAM writes are dropped when error detection is enabled.
    assign ram_we_s  = wr_req_s & ~io_hit_s & ~bad_addr_s;

`ifdef DMEM_ERR_EN
    logic err_q, err_d;

    assign bad_addr_s = ~io_hit_s & (DADDR[29:AW] != {(30-AW){1'b0}});
    assign err_s      = err_q;

    // Sticky illegal-access flag, cleared only by reset.
    always_comb begin
        err_d = err_q;
        if (DREQ && bad_addr_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error flag register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    // Upper address bits simply alias into the RAM in this build.
    logic unused_hi_s;

    assign unused_hi_s = |DADDR[29:AW];
    assign bad_addr_s  = 1'b0;
    assign err_s       = 1'b0;
`endif

    // Next-state for read data, console, halt flag and cycle counter.
    always_comb begin
        rdata_d      = rdata_q;
        cons_valid_d = 1'b0;
        cons_data_d  = cons_data_q;
        halt_d       = halt_q;
        cnt_d        = halt_q ? cnt_q : (cnt_q + 32'd1);

        // Reads see the state present at the sampling edge.
        if (rd_req_s) begin
            if (io_hit_s) begin
                case (io_off_s)
                    OFF_CONS:   rdata_d = cons_data_q;
                    OFF_CNT:    rdata_d = cnt_q;
                    OFF_HALT:   rdata_d = {31'd0, halt_q};
                    OFF_STATUS: rdata_d = {30'd0, err_s, halt_q};
                    default:    rdata_d = 32'd0;
                endcase
            end else if (bad_addr_s) begin
                rdata_d = 32'hDEADBEEF;
            end else begin
                rdata_d = mem[ram_idx_s];
            end
        end else begin
            rdata_d = rdata_q;
        end

        if (wr_req_s && io_hit_s) begin
            case (io_off_s)
                OFF_CONS: begin
                    cons_data_d  = DWDATA;
                    cons_valid_d = 1'b1;
                end
                OFF_CNT:  cnt_d = DWDATA;
                OFF_HALT: begin
                    if (DWDATA != 32'd0) begin
                        halt_d = 1'b1;
                    end else begin
                        halt_d = halt_q;
                    end
                end
                default:  halt_d = halt_q;
            endcase
        end else begin
            halt_d = halt_q;
        end
    end

    // Register update; reset drops any same-cycle request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata_q      <= 32'd0;
            cons_valid_q <= 1'b0;
            cons_data_q  <= 32'd0;
            halt_q       <= 1'b0;
            cnt_q        <= CNT_RST;
        end else begin
            rdata_q      <= rdata_d;
            cons_valid_q <= cons_valid_d;
            cons_data_q  <= cons_data_d;
            halt_q       <= halt_d;
            cnt_q        <= cnt_d;
        end
    end

    // RAM write port.
    always_ff @(posedge CLK) begin
        if (!RST && ram_we_s) begin
            mem[ram_idx_s] <= DWDATA;
        end
    end

    assign DRDATA     = rdata_q;
    assign CONS_VALID = cons_valid_q;
    assign CONS_DATA  = cons_data_q;
    assign HALT       = halt_q;
    assign ERR        = err_s;

endmodule

// File: tb/tb_toy_dmem_responder.sv
// Testbench for toy_dmem_responder: directed vector table with constant
// expectations, then a RAM fill and randomized traffic against a reference model.
module tb_toy_dmem_responder;

    localparam int          AW        = 10;
    localparam int          RAM_WORDS = 1 << AW;
    localparam logic [29:0] IO        = 30'h3FFFFFF0;
    localparam logic [31:0] CNT_INIT  = 32'h0;
`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        DREQ = 1'b0;
    logic        DRW = 1'b0;
    logic [29:0] DADDR = 30'd0;
    logic [31:0] DWDATA = 32'd0;
    logic [31:0] DRDATA;
    logic        CONS_VALID;
    logic [31:0] CONS_DATA;
    logic        HALT;
    logic        ERR;

    int checks = 0;
    int failures = 0;

    toy_dmem_responder #(.AW(AW), .IO_BASE(IO), .CNT_RST(CNT_INIT)) dut (
        .CLK(CLK), .RST(RST), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR),
        .DWDATA(DWDATA), .DRDATA(DRDATA), .CONS_VALID(CONS_VALID),
        .CONS_DATA(CONS_DATA), .HALT(HALT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    logic [31:0] m_ram [RAM_WORDS];
    bit          m_known [RAM_WORDS];
    logic [31:0] m_rd = 32'd0;
    bit          m_rd_known = 1'b1;
    bit          m_cv = 1'b0;
    logic [31:0] m_cd = 32'd0;
    bit          m_halt = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] m_cnt = CNT_INIT;

    task automatic model(input bit rst, input bit req, input bit rw,
                         input logic [29:0] a, input logic [31:0] w);
        bit          io;
        bit          bad;
        int          idx;
        int          off;
        logic [31:0] next_cnt;
        io  = ((a >> 2) == (IO >> 2));
        bad = ERR_EN && !io && (int'(a) >= RAM_WORDS);
        idx = int'(a) % RAM_WORDS;
        off = int'(a) % 4;
        if (rst) begin
            m_rd = 32'd0; m_rd_known = 1'b1; m_cv = 1'b0; m_cd = 32'd0;
            m_halt = 1'b0; m_err = 1'b0; m_cnt = CNT_INIT;
            return;
        end
        next_cnt = m_halt ? m_cnt : m_cnt + 32'd1;
        m_cv = 1'b0;
        if (req && !rw) begin
            m_rd_known = 1'b1;
            if (io) begin
                if (off == 0)      m_rd = m_cd;
                else if (off == 1) m_rd = m_cnt;
                else if (off == 2) m_rd = {31'd0, m_halt};
                else               m_rd = {30'd0, m_err, m_halt};
            end else if (bad) begin
                m_rd = 32'hDEADBEEF;
            end else begin
                m_rd = m_ram[idx];
                m_rd_known = m_known[idx];
            end
        end
        if (req && rw) begin
            if (io) begin
                if (off == 0) begin m_cd = w; m_cv = 1'b1; end
                else if (off == 1) next_cnt = w;
                else if (off == 2 && w != 32'd0) m_halt = 1'b1;
            end else if (!bad) begin
                m_ram[idx] = w;
                m_known[idx] = 1'b1;
            end
        end
        if (req && bad) m_err = 1'b1;
        m_cnt = next_cnt;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, advance the model at the edge, compare after it.
    task automatic step(input bit rst, input bit req, input bit rw,
                        input logic [29:0] a, input logic [31:0] w);
        RST = rst; DREQ = req; DRW = rw; DADDR = a; DWDATA = w;
        @(posedge CLK);
        model(rst, req, rw, a, w);
        #1;
        chk("model_cons_valid", {31'd0, CONS_VALID}, {31'd0, m_cv});
        chk("model_cons_data", CONS_DATA, m_cd);
        chk("model_halt", {31'd0, HALT}, {31'd0, m_halt});
        chk("model_err", {31'd0, ERR}, {31'd0, m_err});
        if (m_rd_known) chk("model_drdata", DRDATA, m_rd);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst, req, rw;
        logic [29:0] a;
        logic [31:0] w;
        bit          c_rd;  logic [31:0] e_rd;
        bit          c_cv;  bit          e_cv;
        bit          c_cd;  logic [31:0] e_cd;
        bit          c_h;   bit          e_h;
        bit          c_e;   bit          e_e;
    } vec_t;

    vec_t tbl [64];
    int   n = 0;

    task automatic add(input bit rst, input bit req, input bit rw,
                       input logic [29:0] a, input logic [31:0] w);
        tbl[n] = '{rst, req, rw, a, w, 1'b0, 32'd0, 1'b0, 1'b0,
                   1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        n++;
    endtask
    task automatic ex_rd(input logic [31:0] v); tbl[n-1].c_rd = 1'b1; tbl[n-1].e_rd = v; endtask
    task automatic ex_cv(input bit v);          tbl[n-1].c_cv = 1'b1; tbl[n-1].e_cv = v; endtask
    task automatic ex_cd(input logic [31:0] v); tbl[n-1].c_cd = 1'b1; tbl[n-1].e_cd = v; endtask
    task automatic ex_h(input bit v);           tbl[n-1].c_h  = 1'b1; tbl[n-1].e_h  = v; endtask
    task automatic ex_e(input bit v);           tbl[n-1].c_e  = 1'b1; tbl[n-1].e_e  = v; endtask

    task automatic idle(); add(1'b0, 1'b0, 1'b0, 30'd0, 32'd0); endtask
    task automatic wr(input logic [29:0] a, input logic [31:0] w); add(1'b0, 1'b1, 1'b1, a, w); endtask
    task automatic rd(input logic [29:0] a); add(1'b0, 1'b1, 1'b0, a, 32'd0); endtask

    initial begin
        // Reset state
        add(1'b1, 1'b0, 1'b0, 30'd0, 32'd0);
        ex_rd(32'd0); ex_cv(1'b0); ex_cd(32'd0); ex_h(1'b0); ex_e(1'b0);
        idle(); ex_rd(32'd0); ex_cv(1'b0); ex_h(1'b0);
        // RAM write, read-after-write, read data holds over idles
        wr(30'd5, 32'h12345678);
        rd(30'd5);   ex_rd(32'h12345678);
        idle();      ex_rd(32'h12345678);
        idle();      ex_rd(32'h12345678);
        idle();      ex_rd(32'h12345678);
        // Back-to-back console writes
        wr(IO, 32'h41); ex_cv(1'b1); ex_cd(32'h41);
        wr(IO, 32'h41); ex_cv(1'b1); ex_cd(32'h41);
        idle();         ex_cv(1'b0); ex_cd(32'h41);
        rd(IO);         ex_rd(32'h41); ex_cv(1'b0);
        // Counter wrap
        wr(IO + 30'd1, 32'hFFFFFFFE);
        idle();
        idle();
        rd(IO + 30'd1); ex_rd(32'h00000000);
        rd(IO + 30'd1); ex_rd(32'h00000001);
        // Halt: zero write ignored, nonzero sets, counter freezes
        wr(IO + 30'd2, 32'd0); ex_h(1'b0);
        wr(IO + 30'd1, 32'h100);
        wr(IO + 30'd2, 32'd1); ex_h(1'b1);
        rd(IO + 30'd1); ex_rd(32'h101); ex_h(1'b1);
        idle(); idle(); idle(); idle();
        rd(IO + 30'd1); ex_rd(32'h101);
        rd(IO + 30'd3); ex_rd(32'h1);
        rd(IO + 30'd2); ex_rd(32'h1);
        // Still serviced while halted; reset during a read drops it
        wr(30'd9, 32'hAA);
        rd(30'd9);      ex_rd(32'hAA);
        add(1'b1, 1'b1, 1'b0, IO + 30'd3, 32'd0);
        ex_rd(32'd0); ex_h(1'b0); ex_cv(1'b0); ex_cd(32'd0); ex_e(1'b0);
        rd(IO + 30'd1); ex_rd(CNT_INIT);
        rd(IO + 30'd1); ex_rd(CNT_INIT + 32'd1);
        rd(30'd5);      ex_rd(32'h12345678);
        // Out-of-range access: error or alias depending on build
        wr(30'd0, 32'h55);
        wr(30'h400, 32'h99); ex_e(ERR_EN);
        rd(30'd0);      ex_rd(ERR_EN ? 32'h55 : 32'h99);
        rd(30'h400);    ex_rd(ERR_EN ? 32'hDEADBEEF : 32'h99); ex_e(ERR_EN);
        rd(IO + 30'd3); ex_rd(ERR_EN ? 32'h2 : 32'h0);
        // Reset beats a same-cycle write
        add(1'b1, 1'b1, 1'b1, 30'd9, 32'h77); ex_e(1'b0);
        rd(30'd9);      ex_rd(32'hAA);

        for (int i = 0; i < n; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].rw, tbl[i].a, tbl[i].w);
            if (tbl[i].c_rd) chk($sformatf("vec%0d_drdata", i), DRDATA, tbl[i].e_rd);
            if (tbl[i].c_cv) chk($sformatf("vec%0d_cons_valid", i), {31'd0, CONS_VALID}, {31'd0, tbl[i].e_cv});
            if (tbl[i].c_cd) chk($sformatf("vec%0d_cons_data", i), CONS_DATA, tbl[i].e_cd);
            if (tbl[i].c_h)  chk($sformatf("vec%0d_halt", i), {31'd0, HALT}, {31'd0, tbl[i].e_h});
            if (tbl[i].c_e)  chk($sformatf("vec%0d_err", i), {31'd0, ERR}, {31'd0, tbl[i].e_e});
        end

        // Fill the RAM so every later read has a known answer
        for (int i = 0; i < RAM_WORDS; i++) begin
            step(1'b0, 1'b1, 1'b1, 30'(i), $urandom);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int          kind;
            logic [29:0] a;
            logic [31:0] w;
            bit          r;
            kind = $urandom_range(0, 9);
            if (kind <= 3)      a = 30'($urandom_range(0, 15));
            else if (kind == 4) a = 30'($urandom_range(0, RAM_WORDS - 1));
            else if (kind <= 7) a = IO + 30'($urandom_range(0, 3));
            else if (kind == 8) a = 30'($urandom_range(1, 15) * RAM_WORDS + $urandom_range(0, RAM_WORDS - 1));
            else                a = 30'($urandom);
            w = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 7) == 0) w = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
            r = ($urandom_range(0, 99) == 0);
            step(r, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, a, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
